// File: rtl/alu_regfile_psr.sv
// alu_regfile_psr: operand-supply and write-back stage around the 16-bit ALU.
// - 16 x 16-bit register file with two combinational read ports (A, B).
// - One-stage write-back register. Reads bypass from this register when it
//   holds the addressed entry.
// - 5-bit PSR (Z C F N L = bits 4..0) with per-bit update mask. The carry
//   bit is fed back to the ALU as Cin.
// Optional build macro ZERO_REG_EN: register 0 reads as zero and is never
// written.
module alu_regfile_psr #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int FLAG_W = 5,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ra_addr,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] flags_mask,
  output logic              cin_out,
  output logic [FLAG_W-1:0] psr_out,
  output logic              wb_busy
);

  localparam int CARRY_BIT = 3;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic [FLAG_W-1:0] psr_q,      psr_d;
  logic              wr_accept;

  // Decide whether a write request enters the write-back stage.
`ifdef ZERO_REG_EN
  assign wr_accept = wr_en && (wr_addr != '0);
`else
  assign wr_accept = wr_en;
`endif

  // Next state of the write-back stage and the PSR.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    wb_valid_d = wr_accept;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wr_accept) begin
      wb_addr_d = wr_addr;
      wb_data_d = wr_data;
    end
    // Masked bits take the old value. An X on flags_in under a zero mask is
    // ANDed away, so it never reaches the PSR.
    psr_d = (flags_mask & flags_in) | (~flags_mask & psr_q);
  end

  // Commit a pending write-back into the array.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid_q) regs_d[wb_addr_q] = wb_data_q;
  end

  // State register. Reset discards any pending write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset because software relies on every register reading zero after reset. Without that need, a memory is left unreset so it can map to RAM.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      psr_q      <= '0;
    end else begin
      // NOTE: state uses non-blocking assignment, so every flop samples pre-edge values and write-back ordering cannot race.
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      psr_q      <= psr_d;
    end
  end

  // Read port A: bypass from the write-back stage, otherwise read the array.
  always_comb begin
    a_out = regs_q[ra_addr];
    if (wb_valid_q && (wb_addr_q == ra_addr)) a_out = wb_data_q;
`ifdef ZERO_REG_EN
    if (ra_addr == '0) a_out = '0;
`endif
  end

  // Read port B: same priority as port A.
  always_comb begin
    b_out = regs_q[rb_addr];
    if (wb_valid_q && (wb_addr_q == rb_addr)) b_out = wb_data_q;
`ifdef ZERO_REG_EN
    if (rb_addr == '0) b_out = '0;
`endif
  end

  assign cin_out = psr_q[CARRY_BIT];
  assign psr_out = psr_q;
  assign wb_busy = wb_valid_q;

endmodule

// File: tb/tb_alu_regfile_psr.sv
// Directed testbench for alu_regfile_psr: reset, bypass, back-to-back
// writes, dual read ports, PSR masking and register-0 behaviour.
module tb_alu_regfile_psr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ra_addr, rb_addr, wr_addr;
  logic [15:0] a_out, b_out, wr_data;
  logic        wr_en;
  logic [4:0]  flags_in, flags_mask, psr_out;
  logic        cin_out, wb_busy;

  int checks = 0;
  int errors = 0;

  alu_regfile_psr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .a_out      (a_out),
    .b_out      (b_out),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flags_in   (flags_in),
    .flags_mask (flags_mask),
    .cin_out    (cin_out),
    .psr_out    (psr_out),
    .wb_busy    (wb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    flags_in = '0; flags_mask = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    ra_addr = '0; rb_addr = '0;
    idle();
    #12;
    check("reset_a",   a_out, 16'h0000);
    check("reset_psr", {11'd0, psr_out}, 16'h0000);
    check("reset_busy", {15'd0, wb_busy}, 16'h0000);
    rst_n = 1'b1;
    step();

    // Pending write to r5 and a PSR update, then an asynchronous reset mid-cycle.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    flags_in = 5'b10101; flags_mask = 5'b11111;
    ra_addr = 4'd5;
    step();
    idle();
    check("r5_bypass", a_out, 16'hBEEF);
    check("r5_busy",   {15'd0, wb_busy}, 16'h0001);
    check("psr_all",   {11'd0, psr_out}, 16'h0015);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {15'd0, wb_busy}, 16'h0000);
    check("arst_psr",  {11'd0, psr_out}, 16'h0000);
    check("arst_cin",  {15'd0, cin_out}, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i); rb_addr = 4'(15 - i);
      #1;
      check("arst_a", a_out, 16'h0000);
      check("arst_b", b_out, 16'h0000);
    end
    #1 rst_n = 1'b1;
    ra_addr = 4'd5;
    step();
    check("r5_after_rst", a_out, 16'h0000);

    // Read-after-write bypass, then the value arrives in the array.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; ra_addr = 4'd3;
    step();
    idle();
    check("raw_bypass", a_out, 16'h1234);
    step();
    check("raw_array", a_out, 16'h1234);
    check("raw_busy",  {15'd0, wb_busy}, 16'h0000);

    // Back-to-back writes to one address: the later write wins.
    ra_addr = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0001;
    step();
    check("b2b_first", a_out, 16'h0001);
    wr_data = 16'h0002;
    step();
    idle();
    check("b2b_second", a_out, 16'h0002);
    step();
    check("b2b_final", a_out, 16'h0002);

    // Dual read ports, including a port-B bypass.
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hAAAA;
    step();
    wr_addr = 4'd2; wr_data = 16'h5555; rb_addr = 4'd2;
    step();
    idle();
    check("b_bypass", b_out, 16'h5555);
    step();
    ra_addr = 4'd1; rb_addr = 4'd2;
    #1;
    check("dual_a", a_out, 16'hAAAA);
    check("dual_b", b_out, 16'h5555);
    ra_addr = 4'd2;
    #1;
    check("same_a", a_out, 16'h5555);
    check("same_b", b_out, 16'h5555);
    ra_addr = 4'd3;
    #1;
    check("r3_kept", a_out, 16'h1234);

    // PSR masking, independent of wr_en.
    flags_in = 5'b11111; flags_mask = 5'b01000;
    step();
    check("psr_mask_c", {11'd0, psr_out}, 16'h0008);
    check("cin_set",    {15'd0, cin_out}, 16'h0001);
    flags_in = 5'b00000; flags_mask = 5'b00000;
    step();
    check("psr_hold", {11'd0, psr_out}, 16'h0008);
    flags_in = 5'bxxxxx; flags_mask = 5'b00000;
    step();
    check("psr_x_block", {11'd0, psr_out}, 16'h0008);
    flags_in = 5'b10000; flags_mask = 5'b10001;
    step();
    check("psr_zl", {11'd0, psr_out}, 16'h0018);
    check("cin_kept", {15'd0, cin_out}, 16'h0001);
    flags_in = 5'b00000; flags_mask = 5'b01000;
    step();
    check("cin_clear", {15'd0, cin_out}, 16'h0000);
    idle();

    // Write to register 0.
    ra_addr = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    step();
    idle();
`ifdef ZERO_REG_EN
    check("r0_bypass", a_out, 16'h0000);
    check("r0_busy",   {15'd0, wb_busy}, 16'h0000);
    step();
    check("r0_array",  a_out, 16'h0000);
`else
    check("r0_bypass", a_out, 16'hFFFF);
    check("r0_busy",   {15'd0, wb_busy}, 16'h0001);
    step();
    check("r0_array",  a_out, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
